// File: rtl/route_editor.sv
// Front-panel routing editor: click pulses walk an IDLE/SEL_IN/SEL_OUT session and toggle matrix bits.
// Optional ROUTE_EDITOR_THRU_DEFAULT_EN makes reset load the identity (thru) route instead of all zero.
module route_editor #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4,
  parameter int TIMEOUT = 50000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_mode,
  input  logic                       btn_next,
  input  logic                       btn_prev,
  input  logic                       btn_toggle,
  output logic [NUM_IN*NUM_OUT-1:0]  route_matrix,
  output logic [$clog2(NUM_IN)-1:0]  cursor_in,
  output logic [$clog2(NUM_OUT)-1:0] cursor_out,
  output logic [1:0]                 edit_state,
  output logic                       changed
);

  localparam int IW = $clog2(NUM_IN);
  localparam int OW = $clog2(NUM_OUT);
  localparam int CW = $clog2(TIMEOUT);
  localparam int MW = NUM_IN * NUM_OUT;

  localparam logic [IW-1:0] IN_LAST    = IW'(NUM_IN - 1);
  localparam logic [OW-1:0] OUT_LAST   = OW'(NUM_OUT - 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEL_IN  = 2'd1,
    SEL_OUT = 2'd2
  } state_t;

  function automatic logic [MW-1:0] reset_route();
    logic [MW-1:0] r;
    r = '0;
`ifdef ROUTE_EDITOR_THRU_DEFAULT_EN
    for (int i = 0; i < NUM_IN && i < NUM_OUT; i++) begin
      r[i*NUM_OUT + i] = 1'b1;
    end
`endif
    return r;
  endfunction

  localparam logic [MW-1:0] RESET_ROUTE = reset_route();

  state_t        state, state_next;
  logic [IW-1:0] cin_next;
  logic [OW-1:0] cout_next;
  logic [MW-1:0] route_next;
  logic          changed_next;
  logic [CW-1:0] timer, timer_next;
  logic          any_pulse, step_up, step_down;

  assign edit_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cursor_in    <= '0;
      cursor_out   <= '0;
      route_matrix <= RESET_ROUTE;
      changed      <= 1'b0;
      timer        <= '0;
    end else begin
      state        <= state_next;
      cursor_in    <= cin_next;
      cursor_out   <= cout_next;
      route_matrix <= route_next;
      changed      <= changed_next;
      timer        <= timer_next;
    end
  end

  always_comb begin
    state_next   = state;
    cin_next     = cursor_in;
    cout_next    = cursor_out;
    route_next   = route_matrix;
    changed_next = 1'b0;
    timer_next   = timer;
    any_pulse    = btn_mode | btn_next | btn_prev | btn_toggle;
    step_up      = btn_next & ~btn_prev;
    step_down    = btn_prev & ~btn_next;

    // Cursor moves and the toggle all act on the cursor values held before this edge.
    case (state)
      SEL_IN: begin
        if (step_up) begin
          cin_next = (cursor_in == IN_LAST) ? '0 : cursor_in + 1'b1;
        end else if (step_down) begin
          cin_next = (cursor_in == '0) ? IN_LAST : cursor_in - 1'b1;
        end
      end
      SEL_OUT: begin
        if (step_up) begin
          cout_next = (cursor_out == OUT_LAST) ? '0 : cursor_out + 1'b1;
        end else if (step_down) begin
          cout_next = (cursor_out == '0) ? OUT_LAST : cursor_out - 1'b1;
        end
        if (btn_toggle) begin
          for (int i = 0; i < NUM_IN; i++) begin
            for (int o = 0; o < NUM_OUT; o++) begin
              if (cursor_in == IW'(i) && cursor_out == OW'(o)) begin
                route_next[i*NUM_OUT + o] = ~route_matrix[i*NUM_OUT + o];
              end
            end
          end
          changed_next = 1'b1;
        end
      end
      default: ;
    endcase

    // A pulse in the final idle cycle keeps the session alive.
    if (state == IDLE || any_pulse) begin
      timer_next = '0;
    end else if (timer == TIMER_LAST) begin
      timer_next = '0;
      state_next = IDLE;
    end else if (timer != '1) begin
      timer_next = timer + 1'b1;
    end

    if (btn_mode) begin
      case (state)
        IDLE:    state_next = SEL_IN;
        SEL_IN:  state_next = SEL_OUT;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_editor.sv
// Scoreboard bench for route_editor (4x4, TIMEOUT=16): the driver queues hand-computed expectations,
// and the monitor checks each one after the clock edge it belongs to.
module tb_route_editor;

  logic        clk;
  logic        rst;
  logic        btn_mode, btn_next, btn_prev, btn_toggle;
  logic [15:0] route_matrix;
  logic [1:0]  cursor_in, cursor_out, edit_state;
  logic        changed;

  typedef struct {
    int          due;
    string       name;
    logic [1:0]  st;
    logic [1:0]  ci;
    logic [1:0]  co;
    logic [15:0] rm;
    logic        ch;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          tests;
  int          fails;
  logic [15:0] r0, ra, rb;

  route_editor #(.NUM_IN(4), .NUM_OUT(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .btn_toggle   (btn_toggle),
    .route_matrix (route_matrix),
    .cursor_in    (cursor_in),
    .cursor_out   (cursor_out),
    .edit_state   (edit_state),
    .changed      (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a few ns after each edge, retire every expectation that falls due at this edge.
  always @(posedge clk) begin
    #3;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (e.due < cyc) begin
        fails++;
        $display("[TB] FAIL %s: expectation for edge %0d not checked, now at edge %0d", e.name, e.due, cyc);
      end else if ({edit_state, cursor_in, cursor_out, route_matrix, changed} !==
                   {e.st, e.ci, e.co, e.rm, e.ch}) begin
        fails++;
        $display("[TB] FAIL %s: got state=%0d in=%0d out=%0d route=%h changed=%b, expected state=%0d in=%0d out=%0d route=%h changed=%b",
                 e.name, edit_state, cursor_in, cursor_out, route_matrix, changed,
                 e.st, e.ci, e.co, e.rm, e.ch);
      end
    end
  end

  task automatic push_exp(input int due, input string name, input logic [1:0] st,
                          input logic [1:0] ci, input logic [1:0] co,
                          input logic [15:0] rm, input logic ch);
    exp_t e;
    e.due  = due;
    e.name = name;
    e.st   = st;
    e.ci   = ci;
    e.co   = co;
    e.rm   = rm;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  // btns = {mode, next, prev, toggle}; the expectation describes the outputs after the next edge.
  task automatic apply_stimulus(input logic [3:0] btns, input bit chk, input string name,
                                input logic [1:0] st, input logic [1:0] ci, input logic [1:0] co,
                                input logic [15:0] rm, input logic ch);
    @(posedge clk);
    #1;
    {btn_mode, btn_next, btn_prev, btn_toggle} = btns;
    if (chk) push_exp(cyc + 1, name, st, ci, co, rm, ch);
  endtask

  task automatic apply_async_reset(input string name);
    @(posedge clk);
    #1;
    {btn_mode, btn_next, btn_prev, btn_toggle} = 4'b0000;
    rst = 1'b1;
    push_exp(cyc, name, 2'd0, 2'd0, 2'd0, r0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_output();
    repeat (3) @(posedge clk);
    #5;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef ROUTE_EDITOR_THRU_DEFAULT_EN
    r0 = 16'h8421;
`else
    r0 = 16'h0000;
`endif
    ra = r0 ^ 16'h0800;
    rb = ra ^ 16'h0020;
    cyc = 0; tests = 0; fails = 0;
    rst = 1'b1;
    {btn_mode, btn_next, btn_prev, btn_toggle} = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    apply_stimulus(4'b0000, 1, "reset_state",       2'd0, 2'd0, 2'd0, r0, 1'b0);
    apply_stimulus(4'b1000, 1, "t1_mode_sel_in",    2'd1, 2'd0, 2'd0, r0, 1'b0);
    apply_stimulus(4'b0100, 1, "t1_next_in_1",      2'd1, 2'd1, 2'd0, r0, 1'b0);
    apply_stimulus(4'b0100, 1, "t1_next_in_2",      2'd1, 2'd2, 2'd0, r0, 1'b0);
    apply_stimulus(4'b1000, 1, "t1_mode_sel_out",   2'd2, 2'd2, 2'd0, r0, 1'b0);
    apply_stimulus(4'b0100, 1, "t1_next_out_1",     2'd2, 2'd2, 2'd1, r0, 1'b0);
    apply_stimulus(4'b0100, 1, "t1_next_out_2",     2'd2, 2'd2, 2'd2, r0, 1'b0);
    apply_stimulus(4'b0100, 1, "t1_next_out_3",     2'd2, 2'd2, 2'd3, r0, 1'b0);
    apply_stimulus(4'b0001, 1, "t1_toggle_bit11",   2'd2, 2'd2, 2'd3, ra, 1'b1);
    apply_stimulus(4'b0000, 1, "t1_changed_clears", 2'd2, 2'd2, 2'd3, ra, 1'b0);

    apply_stimulus(4'b1000, 1, "t2_to_idle",        2'd0, 2'd2, 2'd3, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t2_sel_in",         2'd1, 2'd2, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0001, 1, "t2_toggle_ignored", 2'd1, 2'd2, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0010, 1, "t2_prev_in_1",      2'd1, 2'd1, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0010, 1, "t2_prev_in_0",      2'd1, 2'd0, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0010, 1, "t2_prev_wrap",      2'd1, 2'd3, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0100, 1, "t2_next_wrap",      2'd1, 2'd0, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0110, 1, "t2_next_prev_cancel", 2'd1, 2'd0, 2'd3, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t2_sel_out",        2'd2, 2'd0, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0010, 1, "t2_prev_out",       2'd2, 2'd0, 2'd2, ra, 1'b0);
    apply_stimulus(4'b0100, 1, "t2_next_out",       2'd2, 2'd0, 2'd3, ra, 1'b0);
    apply_stimulus(4'b0100, 1, "t2_next_out_wrap",  2'd2, 2'd0, 2'd0, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t2_back_idle",      2'd0, 2'd0, 2'd0, ra, 1'b0);

    apply_stimulus(4'b0100, 1, "t3_idle_next",      2'd0, 2'd0, 2'd0, ra, 1'b0);
    apply_stimulus(4'b0010, 1, "t3_idle_prev",      2'd0, 2'd0, 2'd0, ra, 1'b0);
    apply_stimulus(4'b0001, 1, "t3_idle_toggle",    2'd0, 2'd0, 2'd0, ra, 1'b0);

    apply_stimulus(4'b1000, 1, "t4_sel_in",         2'd1, 2'd0, 2'd0, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t4_sel_out",        2'd2, 2'd0, 2'd0, ra, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      apply_stimulus(4'b0000, 1, $sformatf("t4_wait_%0d", k),
                     (k == 16) ? 2'd0 : 2'd2, 2'd0, 2'd0, ra, 1'b0);
    end
    apply_stimulus(4'b1000, 1, "t4b_sel_in",        2'd1, 2'd0, 2'd0, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t4b_sel_out",       2'd2, 2'd0, 2'd0, ra, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      apply_stimulus(4'b0000, 1, $sformatf("t4b_wait_%0d", k), 2'd2, 2'd0, 2'd0, ra, 1'b0);
    end
    apply_stimulus(4'b0100, 1, "t4b_pulse_at_limit", 2'd2, 2'd0, 2'd1, ra, 1'b0);
    apply_stimulus(4'b0000, 1, "t4b_still_sel_out", 2'd2, 2'd0, 2'd1, ra, 1'b0);

    apply_stimulus(4'b1000, 1, "t5_idle",           2'd0, 2'd0, 2'd1, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t5_sel_in",         2'd1, 2'd0, 2'd1, ra, 1'b0);
    apply_stimulus(4'b0100, 1, "t5_next_in",        2'd1, 2'd1, 2'd1, ra, 1'b0);
    apply_stimulus(4'b1000, 1, "t5_sel_out",        2'd2, 2'd1, 2'd1, ra, 1'b0);
    apply_stimulus(4'b1101, 1, "t5_toggle_next_mode", 2'd0, 2'd1, 2'd2, rb, 1'b1);
    apply_stimulus(4'b0000, 1, "t5_after_combo",    2'd0, 2'd1, 2'd2, rb, 1'b0);

    apply_stimulus(4'b1000, 1, "t6_sel_in",         2'd1, 2'd1, 2'd2, rb, 1'b0);
    apply_stimulus(4'b0100, 0, "t6_next_unchecked", 2'd1, 2'd2, 2'd2, rb, 1'b0);
    apply_async_reset("t6_async_reset");
    apply_stimulus(4'b0000, 1, "t6_after_release",  2'd0, 2'd0, 2'd0, r0, 1'b0);

    check_output();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
